// File: rtl/denorm_16bits.sv
// Two-stage pipelined right-shift denormalizer (inverse of the 16-bit LZD).
// Optional macro DENORM_STICKY_EN adds out_sticky, the OR of all shifted-out bits.
module denorm_16bits #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_p,
    input  logic             in_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
`ifdef DENORM_STICKY_EN
    ,
    output logic             out_sticky
`endif
);

    localparam int SW = 4;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [SW-3:0]    s1_hi;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;
    logic             s2_zero;
    logic             s2_ready;
    logic [WIDTH-1:0] s1_next;
    logic [WIDTH-1:0] s2_next;

    // Fine shift by the low two count bits, coarse nibble shift in the second stage.
    always_comb begin
        s1_next = in_v ? (in_data >> in_p[1:0]) : '0;
        s2_next = s1_data >> {s1_hi, 2'b00};
    end

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_zero  = s2_zero;

`ifdef DENORM_STICKY_EN
    logic             s1_sticky;
    logic             s2_sticky;
    logic [WIDTH-1:0] s1_lost;
    logic [WIDTH-1:0] s2_lost;

    // Bits that fall off the bottom of each stage feed the sticky chain.
    always_comb begin
        s1_lost = in_data & ((WIDTH'(1) << in_p[1:0]) - WIDTH'(1));
        s2_lost = s1_data & ((WIDTH'(1) << {s1_hi, 2'b00}) - WIDTH'(1));
    end

    assign out_sticky = s2_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sticky <= 1'b0;
            s2_sticky <= 1'b0;
        end else begin
            if (in_valid && in_ready)
                s1_sticky <= in_v && (|s1_lost);
            if (s1_valid && s2_ready)
                s2_sticky <= s1_sticky || (|s2_lost);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_hi    <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_zero  <= 1'b1;
        end else begin
            if (in_ready)
                s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                s1_data <= s1_next;
                s1_hi   <= in_p[3:2];
            end
            if (s2_ready)
                s2_valid <= s1_valid;
            if (s1_valid && s2_ready) begin
                s2_data <= s2_next;
                s2_zero <= (s2_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_denorm_16bits.sv
// Scoreboard bench for denorm_16bits: directed beats, stall/backpressure, mid-flight reset.
// Define DENORM_STICKY_EN to also check out_sticky.
module tb_denorm_16bits;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_p;
    logic        in_v;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;
    logic        out_sticky;

    typedef struct {
        logic [15:0] d;
        logic        z;
        logic        s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    denorm_16bits dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_p      (in_p),
        .in_v      (in_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
`ifdef DENORM_STICKY_EN
        ,
        .out_sticky(out_sticky)
`endif
    );

`ifndef DENORM_STICKY_EN
    assign out_sticky = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] d, input logic [3:0] p, input logic v);
        exp_t e;
        logic [15:0] r;
        r = 16'h0;
        for (int i = 0; i < 16; i++)
            if (v && (i + p) < 16) r[i] = d[i + p];
        e.d = r;
        e.z = (r == 16'h0);
        e.s = 1'b0;
        for (int i = 0; i < 16; i++)
            if (v && i < p && d[i]) e.s = 1'b1;
        return e;
    endfunction

    // Caller sits just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input logic v);
        int waitc;
        in_valid = 1'b1;
        in_data  = d;
        in_p     = p;
        in_v     = v;
        @(negedge clk);
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        q.push_back(model(d, p, v));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Outputs are stable between edges; the negedge view is what the next edge transfers.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checkOutput("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                checkOutput("out_data", 32'(out_data), 32'(q[0].d));
                checkOutput("out_zero", 32'(out_zero), 32'(q[0].z));
`ifdef DENORM_STICKY_EN
                checkOutput("out_sticky", 32'(out_sticky), 32'(q[0].s));
`endif
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        int t0;
        int waitc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_p      = 4'd0;
        in_v      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'h0);
        checkOutput("rst_out_zero", 32'(out_zero), 32'd1);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_sticky", 32'(out_sticky), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] single beat and latency");
        applyStimulus(16'h8000, 4'd5, 1'b1);
        @(negedge clk);
        checkOutput("lat_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_data", 32'(out_data), 32'h0400);
        @(posedge clk);
        #1;

        $display("[TB] boundaries");
        applyStimulus(16'hC003, 4'd15, 1'b1);
        applyStimulus(16'hFFFF, 4'd3, 1'b0);
        applyStimulus(16'hA5C3, 4'd0, 1'b1);
        applyStimulus(16'h0001, 4'd1, 1'b1);

        $display("[TB] streaming throughput");
        t0 = cyc;
        for (int i = 0; i < 6; i++)
            applyStimulus(16'($urandom), 4'($urandom_range(0, 15)), 1'b1);
        checkOutput("throughput_cycles", 32'(cyc - t0), 32'd6);

        $display("[TB] backpressure");
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        applyStimulus(16'hF000, 4'd0, 1'b1);
        applyStimulus(16'hF000, 4'd1, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'hF000;
        in_p     = 4'd2;
        in_v     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        applyStimulus(16'hF000, 4'd2, 1'b1);
        applyStimulus(16'hF000, 4'd3, 1'b1);
        waitc = 0;
        while (q.size() != 0 && waitc < 20) begin
            @(posedge clk);
            waitc++;
        end
        checkOutput("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-flight");
        applyStimulus(16'h1234, 4'd4, 1'b1);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        checkOutput("inrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("postrst_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(16'h4000, 4'd14, 1'b1);
        @(negedge clk);
        checkOutput("postrst_lat_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("postrst_lat_valid", 32'(out_valid), 32'd1);
        checkOutput("postrst_data", 32'(out_data), 32'h0001);
        repeat (3) @(posedge clk);
        checkOutput("final_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
